rename_ctrl: RTL and testbench

- Rename controller that sequences the speculative register alias table for the out-of-order core.
- Owns the physical-register free list. Allocates a free physical register per renamed destination and drives the table's remap, and overwrite on flush, controls.
- Returns freed registers on commit and restores the free list on flush.
- Sits between decode, the alias table and the ROB commit port.

---
 rtl/rename_ctrl_if.sv | 34 +++
 rtl/rename_ctrl.sv | 92 +++++++++
 tb/tb_rename_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rename_ctrl_if.sv
// rename_ctrl_if: decode, alias-table, ROB-commit and status signals of the rename controller.
// i_* are driven into the controller, o_* are driven by it.
interface rename_ctrl_if #(parameter int PHYS_W = 6);
    logic              i_stall;
    logic              i_rename_valid;
    logic              i_rename_has_dest;
    logic [4:0]        i_rename_dest;
    logic              o_rename_ready;
    logic [PHYS_W-1:0] o_alloc_phys;
    logic [4:0]        o_reg_to_map;
    logic [PHYS_W-1:0] o_new_mapping;
    logic              o_remap;
    logic              o_overwrite;
    logic              i_commit_valid;
    logic              i_commit_has_dest;
    logic [PHYS_W-1:0] i_commit_old_phys;
    logic              i_flush;
    logic [5:0]        o_free_count;
    logic [31:0]       o_stall_cycles;

    modport master (
        output i_stall, i_rename_valid, i_rename_has_dest, i_rename_dest,
               i_commit_valid, i_commit_has_dest, i_commit_old_phys, i_flush,
        input  o_rename_ready, o_alloc_phys, o_reg_to_map, o_new_mapping,
               o_remap, o_overwrite, o_free_count, o_stall_cycles
    );

    modport slave (
        input  i_stall, i_rename_valid, i_rename_has_dest, i_rename_dest,
               i_commit_valid, i_commit_has_dest, i_commit_old_phys, i_flush,
        output o_rename_ready, o_alloc_phys, o_reg_to_map, o_new_mapping,
               o_remap, o_overwrite, o_free_count, o_stall_cycles
    );
endinterface

// File: rtl/rename_ctrl.sv
// rename_ctrl: physical-register free list and alias-table sequencing with flush recovery.
// Define RENAME_STATS_EN to build the saturating rename-stall cycle counter.
module rename_ctrl #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    parameter int PHYS_W   = 6,
    parameter int FL_DEPTH = NUM_PHYS - NUM_ARCH
) (
    input logic         clk,
    input logic         reset,
    rename_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t            r_state, w_next;
    logic [PHYS_W-1:0] r_fl [FL_DEPTH];
    logic [PTR_W-1:0]  r_spec_head, r_ret_head, r_tail;
    logic [PTR_W-1:0]  w_free_count;
    logic [PHYS_W-1:0] w_head_tag;
    logic              w_needs_dest, w_ready, w_pop, w_push, w_restore;

    assign w_needs_dest = bus.i_rename_has_dest && bus.i_rename_dest != '0;
    assign w_free_count = r_tail - r_spec_head;
    assign w_head_tag   = r_fl[r_spec_head[IDX_W-1:0]];
    assign w_push       = bus.i_commit_valid && bus.i_commit_has_dest;
    assign w_restore    = r_state == RECOVER && !bus.i_stall;
    assign bus.o_free_count = w_free_count;

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= NORMAL;
        else        r_state <= w_next;

    always_comb
        w_next = (r_state == NORMAL) ? (bus.i_flush ? RECOVER : NORMAL)
                                     : (bus.i_stall ? RECOVER : NORMAL);

    // No bypass: an empty list blocks a pop even when a commit pushes this cycle.
    always_comb begin
        w_ready = r_state == NORMAL && !bus.i_stall && !bus.i_flush &&
                  (!w_needs_dest || w_free_count != '0);
        w_pop = bus.i_rename_valid && w_ready && w_needs_dest;
        bus.o_rename_ready = w_ready;
        bus.o_remap        = w_pop;
        bus.o_reg_to_map   = w_pop ? bus.i_rename_dest : '0;
        bus.o_new_mapping  = w_pop ? w_head_tag : '0;
        bus.o_alloc_phys   = w_pop ? w_head_tag : '0;
        bus.o_overwrite    = r_state == RECOVER;
    end

    // Recovery rewinds the speculative head to the retired head, counting a same-cycle commit.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_spec_head <= '0;
            r_ret_head  <= '0;
            r_tail      <= PTR_W'(FL_DEPTH);
        end else begin
            if (w_restore)  r_spec_head <= r_ret_head + PTR_W'(w_push);
            else if (w_pop) r_spec_head <= r_spec_head + 1'b1;
            if (w_push) begin
                r_tail     <= r_tail + 1'b1;
                r_ret_head <= r_ret_head + 1'b1;
            end
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < FL_DEPTH; i++) r_fl[i] <= PHYS_W'(NUM_ARCH + i);
        end else if (w_push) begin
            r_fl[r_tail[IDX_W-1:0]] <= bus.i_commit_old_phys;
        end

`ifdef RENAME_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            r_stall_cycles <= '0;
        else if (r_state == NORMAL && bus.i_rename_valid && !w_ready && r_stall_cycles != '1)
            r_stall_cycles <= r_stall_cycles + 1'b1;

    assign bus.o_stall_cycles = r_stall_cycles;
`else
    assign bus.o_stall_cycles = '0;
`endif

    // A commit into a full free list means the ROB freed a register it never allocated.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(w_push && w_free_count == PTR_W'(FL_DEPTH)));
endmodule

// File: tb/tb_rename_ctrl.sv
// tb_rename_ctrl: vector table, directed corner sequences and random traffic against a
// queue-based free-list model of the rename controller.
module tb_rename_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rename_ctrl_if #(.PHYS_W(6)) bus ();
    rename_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;

    // Model: free tags in pop order, and allocated-but-unretired tags oldest first.
    int          fq[$];
    int          alloc[$];
    bit          rec;
    int unsigned scnt;

    logic        s_ready, s_remap, s_ovw;
    logic [4:0]  s_map;
    logic [5:0]  s_new, s_alloc, s_fc;
    logic [31:0] s_sc;

    typedef struct {
        bit v, hd; int d; bit cv, chd; int old; bit st, fl;
        bit e_ready, e_remap, e_ovw; int e_new, e_fc;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        alloc.delete();
        for (int i = 0; i < 32; i++) fq.push_back(32 + i);
        rec = 1'b0;
        scnt = 0;
    endtask

    task automatic set_in(input bit v, hd, input int d, input bit cv, chd, input int old, input bit st, fl);
        bus.i_rename_valid    = v;
        bus.i_rename_has_dest = hd;
        bus.i_rename_dest     = 5'(d);
        bus.i_commit_valid    = cv;
        bus.i_commit_has_dest = chd;
        bus.i_commit_old_phys = 6'(old);
        bus.i_stall           = st;
        bus.i_flush           = fl;
    endtask

    task automatic sample();
        s_ready = bus.o_rename_ready;
        s_remap = bus.o_remap;
        s_map   = bus.o_reg_to_map;
        s_new   = bus.o_new_mapping;
        s_alloc = bus.o_alloc_phys;
        s_ovw   = bus.o_overwrite;
        s_fc    = bus.o_free_count;
        s_sc    = bus.o_stall_cycles;
    endtask

    // One clock: called 1 time unit after a rising edge, returns 1 unit after the next.
    task automatic cyc(input bit v, hd, input int d, input bit cv, chd, input int old, input bit st, fl);
        bit needs, e_ready, pop;
        int e_new;
        set_in(v, hd, d, cv, chd, old, st, fl);
        needs   = hd && d != 0;
        e_ready = !rec && !st && !fl && (!needs || fq.size() != 0);
        pop     = v && e_ready && needs;
        e_new   = pop ? fq[0] : 0;
        #4;
        sample();
        chk("ready", s_ready, e_ready);
        chk("remap", s_remap, pop);
        chk("reg_to_map", s_map, pop ? d : 0);
        chk("new_mapping", s_new, e_new);
        if (pop) chk("alloc_phys", s_alloc, e_new);
        chk("overwrite", s_ovw, rec);
        chk("free_count", s_fc, fq.size());
        chk("stall_cycles", s_sc, scnt);
        @(posedge clk);
`ifdef RENAME_STATS_EN
        if (!rec && v && !e_ready && scnt != 32'hffff_ffff) scnt++;
`endif
        if (pop) alloc.push_back(fq.pop_front());
        if (cv && chd) begin
            if (alloc.size() > 0) void'(alloc.pop_front());
            fq.push_back(old);
        end
        if (!rec) rec = fl;
        else if (!st) begin
            for (int i = alloc.size() - 1; i >= 0; i--) fq.push_front(alloc[i]);
            alloc.delete();
            rec = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        sample();
        chk("reset_free_count", s_fc, 32);
        chk("reset_overwrite", s_ovw, 0);
        chk("reset_remap", s_remap, 0);
        chk("reset_stall_cycles", s_sc, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int ovw_cycles;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // v hd d cv chd old st fl | ready remap ovw new fc
        tbl[0] = '{1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 0, 32, 32};
        tbl[1] = '{1, 1, 7, 0, 0, 0, 0, 0, 1, 1, 0, 33, 31};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 30};
        tbl[3] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 34, 30};
        tbl[4] = '{1, 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 35, 29};
        tbl[5] = '{0, 0, 0, 1, 1, 2, 0, 0, 1, 0, 0,  0, 28};
        tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 29};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 29};
        tbl[8] = '{1, 1, 6, 0, 0, 0, 0, 0, 1, 1, 0, 33, 32};
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].v, tbl[i].hd, tbl[i].d, tbl[i].cv, tbl[i].chd, tbl[i].old, tbl[i].st, tbl[i].fl);
            chk("tbl_ready", s_ready, tbl[i].e_ready);
            chk("tbl_remap", s_remap, tbl[i].e_remap);
            chk("tbl_reg_to_map", s_map, tbl[i].e_remap ? tbl[i].d : 0);
            chk("tbl_new_mapping", s_new, tbl[i].e_new);
            chk("tbl_overwrite", s_ovw, tbl[i].e_ovw);
            chk("tbl_free_count", s_fc, tbl[i].e_fc);
        end

        // Drain the whole free list, then the empty-list boundaries.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cyc(1, 1, (i % 31) + 1, 0, 0, 0, 0, 0);
            chk("fill_tag", s_new, 32 + i);
        end
        cyc(1, 1, 3, 0, 0, 0, 0, 0);
        chk("empty_blocks_dest", s_ready, 0);
        cyc(1, 0, 3, 0, 0, 0, 0, 0);
        chk("empty_nodest_ready", s_ready, 1);
        chk("empty_nodest_remap", s_remap, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("empty_dest0_ready", s_ready, 1);
        chk("empty_dest0_remap", s_remap, 0);
        cyc(1, 1, 9, 1, 1, 5, 0, 0);
        chk("no_bypass_ready", s_ready, 0);
        cyc(1, 1, 9, 0, 0, 0, 0, 0);
        chk("after_push_ready", s_ready, 1);
        chk("after_push_tag", s_new, 5);

        // Flush held in recovery by stall; a flush under recovery is absorbed.
        do_reset();
        cyc(1, 1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0, 0, 0);
        ovw_cycles = 0;
        cyc(1, 1, 3, 0, 0, 0, 0, 1);
        chk("flush_cycle_ready", s_ready, 0);
        ovw_cycles += int'(s_ovw);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 3, 0, 0, 0, 1, i == 1);
            chk("recover_stall_ready", s_ready, 0);
            ovw_cycles += int'(s_ovw);
        end
        cyc(1, 1, 3, 0, 0, 0, 0, 0);
        chk("recover_release_ready", s_ready, 0);
        ovw_cycles += int'(s_ovw);
        chk("overwrite_cycles", ovw_cycles, 4);
        cyc(1, 1, 4, 0, 0, 0, 0, 0);
        chk("restored_tag", s_new, 32);
        chk("restored_free_count", s_fc, 32);
        chk("restored_overwrite", s_ovw, 0);

        // Reset while recovering.
        cyc(1, 1, 5, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("mid_recover_overwrite", s_ovw, 1);
        do_reset();
        cyc(1, 1, 4, 0, 0, 0, 0, 0);
        chk("post_reset_overwrite", s_ovw, 0);
        chk("post_reset_tag", s_new, 32);

        // Stall counter while the list is empty.
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 1, 7, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 1, 9, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RENAME_STATS_EN
        chk("stall_cycles_count", s_sc, 5);
`else
        chk("stall_cycles_count", s_sc, 0);
`endif

        // Random traffic; commits only when an allocation is outstanding.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit v, hd, cv, chd, st, fl;
            v   = $urandom_range(0, 3) != 0;
            hd  = $urandom_range(0, 3) != 0;
            chd = alloc.size() > 0 && $urandom_range(0, 1) == 1;
            cv  = chd || $urandom_range(0, 3) == 0;
            st  = $urandom_range(0, 4) == 0;
            fl  = $urandom_range(0, 29) == 0;
            cyc(v, hd, int'($urandom_range(0, 31)), cv, chd, int'($urandom_range(0, 63)), st, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
